// File: rtl/operand_bank_seq.sv
// operand_bank_seq
// Upstream operand stage for the 4-input operand multiplexer. Holds four operand
// registers (B0..B3) and drives the multiplexer select S, either from a manually
// loaded value or from a scan sequencer that steps S through 0,1,2,3, holding each
// value for HOLD cycles.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous reset, active high
//   WE/WA/WD    operand register write: register[WA] <= WD when WE
//   SEL_LD      load SEL_IN into S (idle only)
//   SEL_IN      manual select value
//   SCAN_START  start a 0..3 scan of S (idle only, wins over SEL_LD)
//   B0..B3      operand registers
//   S           registered multiplexer select
//   BUSY        high while a scan is running
//   DONE        one-cycle pulse on the first idle cycle after a scan
module operand_bank_seq #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned HOLD   = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              WE,
   input  logic [1:0]        WA,
   input  logic [DATA_W-1:0] WD,
   input  logic              SEL_LD,
   input  logic [1:0]        SEL_IN,
   input  logic              SCAN_START,
   output logic [DATA_W-1:0] B0,
   output logic [DATA_W-1:0] B1,
   output logic [DATA_W-1:0] B2,
   output logic [DATA_W-1:0] B3,
   output logic [1:0]        S,
   output logic              BUSY,
   output logic              DONE
);

   typedef enum logic {StIdle, StScan} state_e;

   // Counter reload value: S is shown on the reload cycle plus HOLD-1 further cycles.
   localparam logic [3:0] HoldInit = 4'(HOLD - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] bank_q [4];
   logic [1:0]        s_q, s_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Operand registers: writes are accepted in every state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 4; i++) begin
            bank_q[i] <= '0;
         end
      end else if (WE) begin
         bank_q[WA] <= WD;
      end
   end

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (SCAN_START) begin
               state_d = StScan;
            end
         end
         StScan: begin
            if (cnt_q == 4'd0 && s_q == 2'd3) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output next values; SEL_LD and SCAN_START are ignored while scanning.
   always_comb begin
      s_d    = s_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (SCAN_START) begin
               s_d    = 2'd0;
               cnt_d  = HoldInit;
               busy_d = 1'b1;
            end else if (SEL_LD) begin
               s_d = SEL_IN;
            end
         end
         StScan: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (s_q != 2'd3) begin
               s_d   = s_q + 2'd1;
               cnt_d = HoldInit;
            end else begin
               // S stays at 3 after the scan; it never wraps back to 0.
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s_q    <= 2'd0;
         cnt_q  <= 4'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign B0   = bank_q[0];
   assign B1   = bank_q[1];
   assign B2   = bank_q[2];
   assign B3   = bank_q[3];
   assign S    = s_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_operand_bank_seq.sv
// Bench for operand_bank_seq: two instances (HOLD=1 and HOLD=3) share one stimulus
// stream and are checked every cycle against a scan-index model, plus literal checks.
module tb_operand_bank_seq;

   logic       CLK = 1'b0;
   logic       RST;
   logic       WE;
   logic [1:0] WA;
   logic [3:0] WD;
   logic       SEL_LD;
   logic [1:0] SEL_IN;
   logic       SCAN_START;

   logic [3:0] b_o [2][4];
   logic [1:0] s_o [2];
   logic       busy_o [2];
   logic       done_o [2];

   int n_vec = 0;
   int n_bad = 0;

   // Model: shared register contents, per-instance select and scan position.
   int m_b    [4];
   int m_s    [2];
   int m_act  [2];
   int m_idx  [2];
   int m_done [2];

   int bcnt [2];
   int dcnt [2];
   int seq0;

   always #5 CLK = ~CLK;

   operand_bank_seq #(.DATA_W(4), .HOLD(1)) u_h1 (
      .CLK(CLK), .RST(RST), .WE(WE), .WA(WA), .WD(WD), .SEL_LD(SEL_LD),
      .SEL_IN(SEL_IN), .SCAN_START(SCAN_START),
      .B0(b_o[0][0]), .B1(b_o[0][1]), .B2(b_o[0][2]), .B3(b_o[0][3]),
      .S(s_o[0]), .BUSY(busy_o[0]), .DONE(done_o[0])
   );

   operand_bank_seq #(.DATA_W(4), .HOLD(3)) u_h3 (
      .CLK(CLK), .RST(RST), .WE(WE), .WA(WA), .WD(WD), .SEL_LD(SEL_LD),
      .SEL_IN(SEL_IN), .SCAN_START(SCAN_START),
      .B0(b_o[1][0]), .B1(b_o[1][1]), .B2(b_o[1][2]), .B3(b_o[1][3]),
      .S(s_o[1]), .BUSY(busy_o[1]), .DONE(done_o[1])
   );

   function automatic int hold_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_b[i] = 0;
      for (int d = 0; d < 2; d++) begin
         m_s[d] = 0; m_act[d] = 0; m_idx[d] = 0; m_done[d] = 0;
      end
   endtask

   // A scan occupies 4*HOLD cycles; S is the scan cycle index divided by HOLD.
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         m_done[d] = 0;
         if (m_act[d] != 0) begin
            if (m_idx[d] == 4 * hold_of(d) - 1) begin
               m_act[d]  = 0;
               m_done[d] = 1;
            end else begin
               m_idx[d]++;
               m_s[d] = m_idx[d] / hold_of(d);
            end
         end else if (SCAN_START) begin
            m_act[d] = 1;
            m_idx[d] = 0;
            m_s[d]   = 0;
         end else if (SEL_LD) begin
            m_s[d] = int'(SEL_IN);
         end
      end
      if (WE) m_b[WA] = int'(WD);
   endtask

   task automatic compare_all();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("H%0d B%0d", hold_of(d), i), int'(b_o[d][i]), m_b[i]);
         end
         chk($sformatf("H%0d S", hold_of(d)), int'(s_o[d]), m_s[d]);
         chk($sformatf("H%0d BUSY", hold_of(d)), int'(busy_o[d]), m_act[d]);
         chk($sformatf("H%0d DONE", hold_of(d)), int'(done_o[d]), m_done[d]);
      end
   endtask

   // Single compare process: model advances on the edge, outputs checked 1 ns later.
   always @(posedge CLK) begin
      if (RST) model_reset();
      else model_edge();
      #1;
      compare_all();
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic clear_inputs();
      WE = 1'b0; WA = 2'd0; WD = 4'd0;
      SEL_LD = 1'b0; SEL_IN = 2'd0; SCAN_START = 1'b0;
   endtask

   // Mid-cycle asynchronous reset, checked before any clock edge.
   task automatic async_reset(input string tag);
      RST = 1'b1;
      #1;
      model_reset();
      compare_all();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s H%0d S", tag, hold_of(d)), int'(s_o[d]), 0);
         chk($sformatf("%s H%0d BUSY", tag, hold_of(d)), int'(busy_o[d]), 0);
         chk($sformatf("%s H%0d DONE", tag, hold_of(d)), int'(done_o[d]), 0);
         chk($sformatf("%s H%0d B3", tag, hold_of(d)), int'(b_o[d][3]), 0);
      end
      #1;
      RST = 1'b0;
      tick();
   endtask

   // Start a scan and observe it for 16 samples; literal timing checks.
   task automatic scan_and_check(input string tag, input logic with_sel);
      SCAN_START = 1'b1;
      SEL_LD = with_sel;
      SEL_IN = 2'd1;
      tick();
      clear_inputs();
      chk({tag, " start H1 S"}, int'(s_o[0]), 0);
      chk({tag, " start H3 BUSY"}, int'(busy_o[1]), 1);
      seq0 = 0;
      for (int d = 0; d < 2; d++) begin
         bcnt[d] = 0;
         dcnt[d] = 0;
      end
      for (int k = 0; k < 16; k++) begin
         if (k > 0) tick();
         if (k < 4) seq0 = (seq0 << 2) | int'(s_o[0]);
         for (int d = 0; d < 2; d++) begin
            bcnt[d] += int'(busy_o[d]);
            dcnt[d] += int'(done_o[d]);
         end
      end
      chk({tag, " H1 S sequence"}, seq0, 'h1B);
      chk({tag, " H1 BUSY cycles"}, bcnt[0], 4);
      chk({tag, " H3 BUSY cycles"}, bcnt[1], 12);
      chk({tag, " H1 DONE pulses"}, dcnt[0], 1);
      chk({tag, " H3 DONE pulses"}, dcnt[1], 1);
      chk({tag, " H1 final S"}, int'(s_o[0]), 3);
      chk({tag, " H3 final S"}, int'(s_o[1]), 3);
   endtask

   initial begin
      logic [3:0] wvals [4];
      bit found;
      wvals = '{4'h3, 4'hA, 4'h5, 4'hF};
      model_reset();
      clear_inputs();
      RST = 1'b1;
      #12;
      RST = 1'b0;
      chk("reset H1 S", int'(s_o[0]), 0);
      chk("reset H3 BUSY", int'(busy_o[1]), 0);
      tick();

      // Register writes on consecutive cycles
      for (int i = 0; i < 4; i++) begin
         WE = 1'b1; WA = 2'(i); WD = wvals[i];
         tick();
         chk($sformatf("write B%0d", i), int'(b_o[0][i]), int'(wvals[i]));
         if (i < 3) chk($sformatf("untouched B%0d", i + 1), int'(b_o[1][i + 1]), 0);
      end
      clear_inputs();
      tick();

      async_reset("midcycle reset");

      for (int i = 0; i < 4; i++) begin
         WE = 1'b1; WA = 2'(i); WD = wvals[i];
         tick();
      end
      clear_inputs();

      // Manual select
      SEL_LD = 1'b1; SEL_IN = 2'd2;
      tick();
      clear_inputs();
      chk("manual H1 S", int'(s_o[0]), 2);
      chk("manual H3 S", int'(s_o[1]), 2);

      // SEL_LD together with SCAN_START: scan wins
      scan_and_check("scan+sel", 1'b1);

      // Back-to-back: restart in the DONE cycle of the HOLD=3 instance
      SCAN_START = 1'b1;
      tick();
      clear_inputs();
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         found = done_o[1];
      end
      chk("H3 DONE seen", int'(found), 1);
      SCAN_START = 1'b1;
      tick();
      clear_inputs();
      chk("b2b H3 S", int'(s_o[1]), 0);
      chk("b2b H3 BUSY", int'(busy_o[1]), 1);

      // Interference during scan: select load, restart and a write to register[S]
      SEL_LD = 1'b1; SEL_IN = 2'd1; SCAN_START = 1'b1;
      WE = 1'b1; WA = 2'd0; WD = 4'h7;
      tick();
      clear_inputs();
      chk("scan write H3 B0", int'(b_o[1][0]), 7);
      chk("scan ignore H3 S", int'(s_o[1]), 0);
      chk("scan ignore H1 S", int'(s_o[0]), 1);
      for (int k = 0; k < 14; k++) tick();
      chk("after interference H3 S", int'(s_o[1]), 3);
      chk("after interference H3 BUSY", int'(busy_o[1]), 0);

      // Abort mid-scan at S=2
      SCAN_START = 1'b1;
      tick();
      clear_inputs();
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         found = (s_o[1] == 2'd2);
      end
      chk("H3 reached S=2", int'(found), 1);
      async_reset("abort");
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("no DONE after abort", int'(done_o[1]), 0);
      end
      scan_and_check("post-abort", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/operand_bank_seq.md
Name: operand_bank_seq

Overview:
Upstream operand stage for the 4-input, 4-bit operand multiplexer. The block holds four 4-bit operand registers that drive B0..B3. It also drives the 2-bit select S, either from a manually loaded value or from an automatic scan sequencer that steps S through 0..3. The multiplexer output In_B is then presented to the datapath one operand at a time.

Parameters:
DATA_W, 4, width of each operand register; 4 for the current multiplexer.
HOLD, 1, clock cycles S holds each value during a scan; legal range 1..15.

Ports:
CLK  input  1  system clock, rising-edge active
RST  input  1  asynchronous reset, active-high
WE  input  1  register write enable
WA  input  2  write address; 0..3 selects B0..B3
WD  input  DATA_W  write data
SEL_LD  input  1  load SEL_IN into S (manual select)
SEL_IN  input  2  manual select value
SCAN_START  input  1  start automatic scan of S = 0,1,2,3
B0  output  DATA_W  operand register 0
B1  output  DATA_W  operand register 1
B2  output  DATA_W  operand register 2
B3  output  DATA_W  operand register 3
S  output  2  select to the multiplexer, registered
BUSY  output  1  high while a scan is in progress
DONE  output  1  one-cycle pulse at scan completion

Behaviour:
- Clocking and reset: single clock CLK; reset RST is asynchronous and active-high.
- Reset values, applied immediately on RST=1 independent of CLK: B0..B3=0, S=0, BUSY=0, DONE=0, state=IDLE, hold counter=0.
- All outputs are registered; no combinational path from any input to any output.
- Register write:
  - On a CLK edge with WE=1, register[WA] <= WD.
  - New value is visible on Bn one cycle after the write edge.
  - Writes are accepted in every state, including SCAN.
  - Only one register is written per cycle.
- States: IDLE, SCAN.
- IDLE:
  - SCAN_START=1 -> state SCAN, S<=0, BUSY<=1, hold counter<=HOLD-1.
  - Otherwise, SEL_LD=1 -> S<=SEL_IN.
  - Otherwise S holds.
  - SCAN_START has priority over SEL_LD in the same cycle.
- SCAN:
  - Each CLK edge with hold counter>0: counter decrements, S holds.
  - Hold counter=0 and S<3: S<=S+1, counter<=HOLD-1.
  - Hold counter=0 and S=3: state IDLE, BUSY<=0, DONE<=1, S stays 3.
  - SEL_LD and SCAN_START are ignored; no restart and no select override.
- Scan timing:
  - Each S value is presented for exactly HOLD cycles.
  - BUSY is high for exactly 4*HOLD cycles.
  - DONE is high for exactly one cycle, the first cycle back in IDLE.
- DONE is cleared on every cycle other than the completion cycle.
- Back-to-back scan: SCAN_START in the cycle DONE=1 (state IDLE) starts a new scan; S<=0 on that edge.
- No wrap-around: S never wraps 3->0 within a scan; it only returns to 0 on a new scan start or reset.
- Write during scan: a write to register[S] during SCAN reaches the multiplexer one cycle later; the scan timing is unaffected.
- RST asserted mid-scan: scan aborts immediately, all reset values apply, and no DONE pulse is generated.
- Writes in the cycle RST deasserts are not guaranteed; the first guaranteed write is on the edge after deassertion.

Test Plan:
- Reset check: assert RST mid-cycle with registers nonzero -> B0..B3=0, S=0, BUSY=0, DONE=0 immediately, without waiting for a CLK edge.
- Register writes: write WA=0..3 with WD=4'h3, 4'hA, 4'h5, 4'hF on consecutive cycles -> each Bn shows its value one cycle after its write edge; other registers unchanged.
- Manual select: in IDLE, SEL_LD=1, SEL_IN=2 -> S=2 next cycle. Assert SEL_LD and SCAN_START together -> scan starts and S=0.
- Scan, HOLD=1: pulse SCAN_START -> S=0,1,2,3 on four consecutive cycles with BUSY=1 throughout; then DONE=1 for one cycle, BUSY=0, S=3. Repeat with HOLD=3 -> each S value held 3 cycles, BUSY high for 12 cycles.
- Scan interference: during a scan, assert SEL_LD=1 with SEL_IN=1 and pulse SCAN_START again -> both ignored, sequence unchanged. Write WA=S with WD=4'h7 -> Bn=7 on the next cycle.
- Abort: assert RST while S=2 in SCAN -> S=0 and BUSY=0 immediately, no DONE pulse. After release, SCAN_START runs a full 0..3 scan normally.
